// File: rtl/nlf_batch_controller.sv
// Purpose : sequencing FSM for the nonlinear-function datapath (softmax/GELU/SiLU/root);
//           runs MAX / FIRST_STAGE / SECOND_STAGE per vector for num_vec vectors per start.
// Latency : state and codes registered; first phase appears the cycle after start is sampled.
// Backpr. : a valid cycle with out_ready=0 holds state, counters and codes, and gates en_mult/en_add.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, mode, num_vec launch request; mode/num_vec latched at launch (num_vec 0 -> 1)
//   out_ready, abort    downstream accept, synchronous kill (beats start)
//   busy, vec_idx       job in progress, 0-based index of current vector
//   max_en, s_in, s_mux, s_mult, s_add, en_mult, en_add   datapath control codes
//   valid, finish       result valid, one-cycle end-of-job pulse
//   perf_cycles         busy cycles of the last job (only with NLF_PERF_CNT_EN defined)
//
// Optional feature macro: NLF_PERF_CNT_EN
module nlf_batch_controller #(
  parameter int DATA_NUM     = 16,
  parameter int STAGE_CYCLES = 4,
  parameter int VEC_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [VEC_W-1:0] num_vec,
  input  logic             out_ready,
  input  logic             abort,
  output logic             busy,
  output logic [VEC_W-1:0] vec_idx,
  output logic             max_en,
  output logic [2:0]       s_in,
  output logic             s_mux,
  output logic [2:0]       s_mult,
  output logic             s_add,
  output logic             en_mult,
  output logic             en_add,
  output logic             valid,
  output logic             finish
`ifdef NLF_PERF_CNT_EN
  ,
  output logic [31:0]      perf_cycles
`endif
);

  localparam int SORT_CYCLES = (DATA_NUM / 2 - 1) * 9 + 1;
  localparam int MAX_CYCLES  = (SORT_CYCLES > STAGE_CYCLES) ? SORT_CYCLES : STAGE_CYCLES;
  localparam int CNT_W       = $clog2(MAX_CYCLES) + 1;

  localparam logic [CNT_W-1:0] SORT_LAST  = CNT_W'(SORT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);

  localparam logic [1:0] M_SOFTMAX = 2'b00;
  localparam logic [1:0] M_ROOT    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MAX    = 3'd1,
    S_FIRST  = 3'd2,
    S_SECOND = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t           r_state,    w_state_nxt;
  logic [1:0]       r_mode,     w_mode_nxt;
  logic [VEC_W-1:0] r_last_idx, w_last_nxt;
  logic [VEC_W-1:0] r_vec_idx,  w_vec_nxt;
  logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;
  logic             w_vec_done;
  logic             w_adv;

  logic       r_busy, r_max_en, r_s_mux, r_s_add, r_en_mult, r_en_add, r_valid, r_finish;
  logic [2:0] r_s_in, r_s_mult;
  logic       w_busy, w_max_en, w_s_mux, w_s_add, w_en_mult, w_en_add, w_valid, w_finish;
  logic [2:0] w_s_in, w_s_mult;

  // A valid cycle only moves on when downstream takes the result.
  assign w_adv = ~r_valid | out_ready;

  // Next-state and counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_last_nxt  = r_last_idx;
    w_vec_nxt   = r_vec_idx;
    w_cnt_nxt   = r_cnt;
    w_vec_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_vec_nxt = '0;
        w_cnt_nxt = '0;
        if (start) begin
          w_mode_nxt  = mode;
          w_last_nxt  = (num_vec == '0) ? '0 : num_vec - VEC_W'(1);
          w_state_nxt = (mode == M_SOFTMAX) ? S_MAX : S_FIRST;
        end
      end
      S_MAX: begin
        if (r_cnt == SORT_LAST) begin
          w_state_nxt = S_FIRST;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_FIRST: begin
        if (w_adv) begin
          if (r_cnt == STAGE_LAST) begin
            if (r_mode == M_ROOT) begin
              w_vec_done = 1'b1;
            end else begin
              w_state_nxt = S_SECOND;
              w_cnt_nxt   = '0;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      S_SECOND: begin
        if (w_adv) begin
          if (r_cnt == STAGE_LAST) w_vec_done = 1'b1;
          else                     w_cnt_nxt  = r_cnt + CNT_W'(1);
        end
      end
      S_FINISH: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_vec_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_vec_nxt   = '0;
      end
    endcase

    // Vector boundary: next vector starts immediately, no IDLE gap.
    if (w_vec_done) begin
      w_cnt_nxt = '0;
      if (r_vec_idx == r_last_idx) begin
        w_state_nxt = S_FINISH;
      end else begin
        w_vec_nxt   = r_vec_idx + VEC_W'(1);
        w_state_nxt = (r_mode == M_SOFTMAX) ? S_MAX : S_FIRST;
      end
    end

    if (abort) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_vec_nxt   = '0;
    end
  end

  // Output codes are decoded from the next state so they register on the
  // same edge as the state they describe.
  always_comb begin
    w_busy    = (w_state_nxt != S_IDLE);
    w_max_en  = 1'b0;
    w_s_in    = 3'd0;
    w_s_mux   = 1'b0;
    w_s_mult  = 3'd0;
    w_s_add   = 1'b0;
    w_en_mult = 1'b0;
    w_en_add  = 1'b0;
    w_valid   = 1'b0;
    w_finish  = 1'b0;
    case (w_state_nxt)
      S_MAX: w_max_en = 1'b1;
      S_FIRST: begin
        w_en_mult = 1'b1;
        case (w_mode_nxt)
          M_SOFTMAX: {w_s_in, w_s_mux, w_s_mult, w_s_add} = {3'd0, 1'b1, 3'd2, 1'b1};
          M_ROOT: begin
            {w_s_in, w_s_mux, w_s_mult, w_s_add} = {3'd4, 1'b0, 3'd1, 1'b0};
            // Root has no second stage; its result leaves on the last first-stage cycle.
            w_valid = (w_cnt_nxt == STAGE_LAST);
          end
          default:   {w_s_in, w_s_mux, w_s_mult, w_s_add} = {3'd2, 1'b1, 3'd3, 1'b0};
        endcase
      end
      S_SECOND: begin
        w_valid  = 1'b1;
        w_en_add = 1'b1;
        if (w_mode_nxt == M_SOFTMAX) begin
          {w_s_in, w_s_mux, w_s_mult, w_s_add} = {3'd1, 1'b0, 3'd0, 1'b1};
          w_en_mult = 1'b1;
        end else begin
          {w_s_in, w_s_mux, w_s_mult, w_s_add} = {3'd3, 1'b0, 3'd0, 1'b1};
        end
      end
      S_FINISH: w_finish = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_mode     <= 2'b00;
      r_last_idx <= '0;
      r_vec_idx  <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_max_en   <= 1'b0;
      r_s_in     <= 3'd0;
      r_s_mux    <= 1'b0;
      r_s_mult   <= 3'd0;
      r_s_add    <= 1'b0;
      r_en_mult  <= 1'b0;
      r_en_add   <= 1'b0;
      r_valid    <= 1'b0;
      r_finish   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mode     <= w_mode_nxt;
      r_last_idx <= w_last_nxt;
      r_vec_idx  <= w_vec_nxt;
      r_cnt      <= w_cnt_nxt;
      r_busy     <= w_busy;
      r_max_en   <= w_max_en;
      r_s_in     <= w_s_in;
      r_s_mux    <= w_s_mux;
      r_s_mult   <= w_s_mult;
      r_s_add    <= w_s_add;
      r_en_mult  <= w_en_mult;
      r_en_add   <= w_en_add;
      r_valid    <= w_valid;
      r_finish   <= w_finish;
    end
  end

  assign busy    = r_busy;
  assign vec_idx = r_vec_idx;
  assign max_en  = r_max_en;
  assign s_in    = r_s_in;
  assign s_mux   = r_s_mux;
  assign s_mult  = r_s_mult;
  assign s_add   = r_s_add;
  // Enables drop in the very cycle a result is refused so the datapath freezes with it.
  assign en_mult = r_en_mult & w_adv;
  assign en_add  = r_en_add & w_adv;
  assign valid   = r_valid;
  assign finish  = r_finish;

`ifdef NLF_PERF_CNT_EN
  logic [31:0] r_perf_cycles;

  // Cleared at launch, counts every busy cycle (stalls included), then holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            r_perf_cycles <= '0;
    else if (r_state == S_IDLE && start && !abort) r_perf_cycles <= '0;
    else if (r_state != S_IDLE)            r_perf_cycles <= r_perf_cycles + 32'd1;
  end

  assign perf_cycles = r_perf_cycles;
`endif

endmodule

// File: tb/tb_nlf_batch_controller.sv
// Purpose : randomized scoreboard bench for nlf_batch_controller against a phase-level reference model.
// Latency : expected per-cycle outputs queued at launch, monitor compares one record per cycle.
// Backpr. : out_ready patterns are generated by the model and replayed by the driver.
module tb_nlf_batch_controller;

  localparam int SORT  = (16 / 2 - 1) * 9 + 1;
  localparam int STAGE = 4;

  typedef struct packed {
    logic       busy;
    logic       chk_idx;
    logic [7:0] vec_idx;
    logic       max_en;
    logic [2:0] s_in;
    logic       s_mux;
    logic [2:0] s_mult;
    logic       s_add;
    logic       en_mult;
    logic       en_add;
    logic       valid;
    logic       finish;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] num_vec = 8'd0;
  logic       out_ready = 1'b1;
  logic       abort = 1'b0;
  logic       busy, max_en, s_mux, s_add, en_mult, en_add, valid, finish;
  logic [7:0] vec_idx;
  logic [2:0] s_in, s_mult;
`ifdef NLF_PERF_CNT_EN
  logic [31:0] perf_cycles;
`endif

  int checks = 0;
  int failures = 0;

  rec_t exp_q[$];
  rec_t tmp_exp[$];
  bit   tmp_rdy[$];
  int   m_p, m_stall_lo, mt;

  always #5 clk = ~clk;

  nlf_batch_controller #(.DATA_NUM(16), .STAGE_CYCLES(4), .VEC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .num_vec(num_vec),
    .out_ready(out_ready), .abort(abort), .busy(busy), .vec_idx(vec_idx),
    .max_en(max_en), .s_in(s_in), .s_mux(s_mux), .s_mult(s_mult), .s_add(s_add),
    .en_mult(en_mult), .en_add(en_add), .valid(valid), .finish(finish)
`ifdef NLF_PERF_CNT_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  function automatic logic [14:0] pack_act();
    return {busy, max_en, s_in, s_mux, s_mult, s_add, en_mult, en_add, valid, finish};
  endfunction

  function automatic logic [14:0] pack_exp(input rec_t r);
    return {r.busy, r.max_en, r.s_in, r.s_mux, r.s_mult, r.s_add, r.en_mult, r.en_add, r.valid, r.finish};
  endfunction

  // Monitor: one expected record per cycle while the scoreboard holds any.
  rec_t mon_e;
  int   mon_n = 0;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n++;
      checks++;
      if (pack_act() !== pack_exp(mon_e) || (mon_e.chk_idx && vec_idx !== mon_e.vec_idx)) begin
        failures++;
        $display("FAIL cycle_rec %0d: got ctl=%h idx=%0d required ctl=%h idx=%0d",
                 mon_n, pack_act(), vec_idx, pack_exp(mon_e), mon_e.vec_idx);
      end
    end
  end

  function automatic bit gen_rdy(input int t);
    if (m_stall_lo > 0 && t >= m_stall_lo && t < m_stall_lo + 3) return 1'b0;
    if (m_p != 0) return ($urandom_range(3) != 0);
    return 1'b1;
  endfunction

  // One model cycle; a result beat repeats as frozen stall cycles until accepted.
  task automatic push_cycle(input rec_t r, input bit vbeat);
    rec_t s;
    bit   rd;
    if (vbeat) begin
      rd = gen_rdy(mt);
      while (!rd) begin
        s = r;
        s.en_mult = 1'b0;
        s.en_add  = 1'b0;
        tmp_exp.push_back(s);
        tmp_rdy.push_back(1'b0);
        mt++;
        rd = gen_rdy(mt);
      end
    end else begin
      rd = ($urandom_range(1) == 1);
    end
    tmp_exp.push_back(r);
    tmp_rdy.push_back(rd);
    mt++;
  endtask

  task automatic build_model(input logic [1:0] md, input int nv);
    int   n;
    rec_t r;
    n = (nv == 0) ? 1 : nv;
    for (int v = 0; v < n; v++) begin
      if (md == 2'b00) begin
        for (int i = 0; i < SORT; i++) begin
          r = '0; r.busy = 1; r.chk_idx = 1; r.vec_idx = 8'(v); r.max_en = 1;
          push_cycle(r, 1'b0);
        end
      end
      for (int i = 0; i < STAGE; i++) begin
        r = '0; r.busy = 1; r.chk_idx = 1; r.vec_idx = 8'(v); r.en_mult = 1;
        case (md)
          2'b00:   begin r.s_in = 0; r.s_mux = 1; r.s_mult = 2; r.s_add = 1; end
          2'b11:   begin r.s_in = 4; r.s_mux = 0; r.s_mult = 1; r.s_add = 0; end
          default: begin r.s_in = 2; r.s_mux = 1; r.s_mult = 3; r.s_add = 0; end
        endcase
        if (md == 2'b11 && i == STAGE - 1) begin
          r.valid = 1;
          push_cycle(r, 1'b1);
        end else begin
          push_cycle(r, 1'b0);
        end
      end
      if (md != 2'b11) begin
        for (int i = 0; i < STAGE; i++) begin
          r = '0; r.busy = 1; r.chk_idx = 1; r.vec_idx = 8'(v);
          r.valid = 1; r.en_add = 1; r.s_add = 1;
          if (md == 2'b00) begin r.s_in = 1; r.en_mult = 1; end
          else             r.s_in = 3;
          push_cycle(r, 1'b1);
        end
      end
    end
    r = '0; r.busy = 1; r.finish = 1;
    push_cycle(r, 1'b0);
  endtask

  // abort_at: cycle (1-based after launch) with abort high, 0 none, -1 random.
  task automatic run_job(input logic [1:0] md, input int nv, input int p,
                         input int stall_lo, input int abort_at, input int n_idle);
    int ab;
    int exp_busy;
    tmp_exp.delete();
    tmp_rdy.delete();
    m_p = p; m_stall_lo = stall_lo; mt = 1;
    build_model(md, nv);
    ab = abort_at;
    if (ab < 0) ab = $urandom_range(tmp_exp.size(), 1);
    if (ab > 0) begin
      while (tmp_exp.size() > ab) begin
        void'(tmp_exp.pop_back());
        void'(tmp_rdy.pop_back());
      end
    end
    for (int i = 0; i < n_idle; i++) begin
      tmp_exp.push_back('0);
      tmp_rdy.push_back($urandom_range(1) == 1);
    end
    exp_busy = 0;
    foreach (tmp_exp[i]) if (tmp_exp[i].busy) exp_busy++;

    @(posedge clk); #1;
    mode = md; num_vec = 8'(nv); start = 1'b1; abort = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    mode = 2'($urandom);
    num_vec = 8'($urandom);
    foreach (tmp_exp[i]) exp_q.push_back(tmp_exp[i]);
    for (int k = 0; k < tmp_rdy.size(); k++) begin
      out_ready = tmp_rdy[k];
      abort = (ab == k + 1);
      @(posedge clk); #1;
    end
    abort = 1'b0;
`ifdef NLF_PERF_CNT_EN
    checks++;
    if (perf_cycles !== 32'(exp_busy)) begin
      failures++;
      $display("FAIL perf_cycles: got %0d required %0d", perf_cycles, exp_busy);
    end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #7;
    checks++;
    if (pack_act() !== 15'd0 || vec_idx !== 8'd0) begin
      failures++;
      $display("FAIL reset_state: got ctl=%h idx=%0d required ctl=0 idx=0", pack_act(), vec_idx);
    end
    #10 rst_n = 1'b1;

    run_job(2'b00, 1, 0, 0, 0, 1);   // softmax, single vector
    run_job(2'b01, 3, 0, 0, 0, 1);   // gelu x3
    run_job(2'b10, 3, 0, 0, 0, 1);   // silu x3
    run_job(2'b11, 2, 0, 0, 0, 1);   // root x2
    run_job(2'b01, 1, 0, 6, 0, 1);   // 3-cycle stall mid-SECOND
    run_job(2'b00, 1, 0, 0, 10, 70); // abort at MAX cycle 10, finish never
    run_job(2'b01, 0, 0, 0, 0, 1);   // num_vec=0 acts as 1
    run_job(2'b11, 1, 1, 0, 0, 1);   // root with random stalls
    for (int j = 0; j < 14; j++) begin
      if ($urandom_range(3) == 0)
        run_job(2'($urandom), $urandom_range(3), 1, 0, -1, 4);
      else
        run_job(2'($urandom), $urandom_range(3), 1, 0, 0, 1);
    end

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size());
    end

    // Asynchronous reset in the middle of SECOND_STAGE.
    @(posedge clk); #1;
    mode = 2'b01; num_vec = 8'd1; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    checks++;
    if (valid !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_valid: got %0b required 1", valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (pack_act() !== 15'd0 || vec_idx !== 8'd0) begin
      failures++;
      $display("FAIL async_reset: got ctl=%h idx=%0d required ctl=0 idx=0", pack_act(), vec_idx);
    end
    #10 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
